// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - back-pressurable pipeline stage with 2-entry skid buffer, sync flush, optional perf counters (PIPE_STAGE_PERF_EN)
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int WORDS  = 2,
   parameter int RN_W   = 5,
   parameter int CTRL_W = 2,
   parameter int CNT_W  = 16
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    flush_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [CTRL_W-1:0]       in_ctrl_i,
   input  logic [WORDS*DATA_W-1:0] in_data_i,
   input  logic [RN_W-1:0]         in_rn_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [CTRL_W-1:0]       out_ctrl_o,
   output logic [WORDS*DATA_W-1:0] out_data_o,
   output logic [RN_W-1:0]         out_rn_o
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]        stall_cnt_o,
   output logic [CNT_W-1:0]        bubble_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic                      in_ready_q, in_ready_d;
   logic [CTRL_W-1:0]         m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
   logic [WORDS*DATA_W-1:0]   m_data_q, m_data_d, s_data_q, s_data_d;
   logic [RN_W-1:0]           m_rn_q, m_rn_d, s_rn_q, s_rn_d;
   logic                      out_valid;
   logic                      in_fire;
   logic                      out_fire;

   assign out_valid = (state_q != ST_EMPTY);
   assign in_fire   = in_valid_i & in_ready_q;
   assign out_fire  = out_valid & out_ready_i;

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid;
   // A bubble must never look like a register write downstream.
   assign out_ctrl_o  = m_ctrl_q & {CTRL_W{out_valid}};
   assign out_data_o  = m_data_q;
   assign out_rn_o    = m_rn_q;

   // Next-state and storage steering; flush overrides every transition.
   always_comb begin
      state_d  = state_q;
      m_ctrl_d = m_ctrl_q;
      m_data_d = m_data_q;
      m_rn_d   = m_rn_q;
      s_ctrl_d = s_ctrl_q;
      s_data_d = s_data_q;
      s_rn_d   = s_rn_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d  = ST_ONE;
                  m_ctrl_d = in_ctrl_i;
                  m_data_d = in_data_i;
                  m_rn_d   = in_rn_i;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  m_ctrl_d = in_ctrl_i;
                  m_data_d = in_data_i;
                  m_rn_d   = in_rn_i;
               end else if (in_fire) begin
                  state_d  = ST_FULL;
                  s_ctrl_d = in_ctrl_i;
                  s_data_d = in_data_i;
                  s_rn_d   = in_rn_i;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_d  = ST_ONE;
                  m_ctrl_d = s_ctrl_q;
                  m_data_d = s_data_q;
                  m_rn_d   = s_rn_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // in_ready is registered from the next state so out_ready never reaches it combinationally.
   always_comb begin
      in_ready_d = (state_d != ST_FULL);
   end

   // State, ready flop and both entry registers; everything clears on reset.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b0;
         m_ctrl_q   <= '0;
         m_data_q   <= '0;
         m_rn_q     <= '0;
         s_ctrl_q   <= '0;
         s_data_q   <= '0;
         s_rn_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         m_ctrl_q   <= m_ctrl_d;
         m_data_q   <= m_data_d;
         m_rn_q     <= m_rn_d;
         s_ctrl_q   <= s_ctrl_d;
         s_data_q   <= s_data_d;
         s_rn_q     <= s_rn_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Saturating event counters; flush does not clear them.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (out_valid && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt_o  = stall_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
   localparam int DATA_W = 32;
   localparam int WORDS  = 2;
   localparam int RN_W   = 5;
   localparam int CTRL_W = 2;
   localparam int CNT_W  = 16;
   localparam int DW     = WORDS * DATA_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic [DW-1:0]     in_data = '0;
   logic [RN_W-1:0]   in_rn = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DW-1:0]     out_data;
   logic [RN_W-1:0]   out_rn;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;
`endif

   pipe_stage_skid #(
      .DATA_W(DATA_W), .WORDS(WORDS), .RN_W(RN_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
   ) dut (
      .clock_i(clk), .reset_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ctrl_i(in_ctrl),
      .in_data_i(in_data), .in_rn_i(in_rn),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl),
      .out_data_o(out_data), .out_rn_o(out_rn)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CTRL_W-1:0] ctrl;
      logic [DW-1:0]     data;
      logic [RN_W-1:0]   rn;
   } ent_t;

   ent_t             q[$];
   logic             m_ready = 1'b0;
   logic [CNT_W-1:0] stall_m = '0;
   logic [CNT_W-1:0] bubble_m = '0;
   int               checks = 0;
   int               errors = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("in_ready", DW'(in_ready), DW'(m_ready));
      chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
      if (q.size() > 0) begin
         chk("out_ctrl", DW'(out_ctrl), DW'(q[0].ctrl));
         chk("out_rn", DW'(out_rn), DW'(q[0].rn));
         chk("out_data", out_data, q[0].data);
      end else begin
         chk("out_ctrl_bubble", DW'(out_ctrl), '0);
      end
   endtask

   // One clock edge: the model consumes the inputs present at the edge, then outputs are compared.
   task automatic tick();
      bit   in_fire;
      bit   out_fire;
      ent_t e;
      @(posedge clk);
      if (q.size() > 0 && !out_ready && stall_m != {CNT_W{1'b1}}) stall_m++;
      if (q.size() == 0 && bubble_m != {CNT_W{1'b1}}) bubble_m++;
      in_fire  = in_valid && m_ready;
      out_fire = (q.size() > 0) && out_ready;
      if (flush) begin
         q.delete();
      end else begin
         if (out_fire) void'(q.pop_front());
         if (in_fire) begin
            e.ctrl = in_ctrl;
            e.data = in_data;
            e.rn   = in_rn;
            q.push_back(e);
         end
      end
      m_ready = (q.size() < 2);
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [RN_W-1:0] r,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_ctrl   = c;
      in_rn     = r;
      in_data   = {$urandom, $urandom};
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      q.delete();
      m_ready  = 1'b0;
      stall_m  = '0;
      bubble_m = '0;
      chk("rst_out_valid", DW'(out_valid), '0);
      chk("rst_out_ctrl", DW'(out_ctrl), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_rn", DW'(out_rn), '0);
      chk("rst_in_ready", DW'(in_ready), '0);
      @(posedge clk);
      #1;
      chk("rst_hold_in_ready", DW'(in_ready), '0);
      rst = 1'b0;
      tick();
      chk("rst_release_in_ready", DW'(in_ready), 1);
   endtask

   initial begin
      // Reset from power-up.
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      do_reset();

      // Reset mid-stream with the stage full and input still valid.
      drive(1'b1, 2'b01, 5'd20, 1'b0, 1'b0); tick();
      drive(1'b1, 2'b10, 5'd21, 1'b0, 1'b0); tick();
      drive(1'b1, 2'b11, 5'd22, 1'b0, 1'b0);
      #2;
      do_reset();

      // Streaming: rn 1..8 back-to-back, each visible one cycle later, no gaps.
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 2'(k), 5'(k), 1'b1, 1'b0);
         tick();
         chk("stream_rn", DW'(out_rn), DW'(k));
         chk("stream_valid", DW'(out_valid), 1);
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0); tick(); tick();

      // Back-pressure: rn 3,4 held, then drained in order.
      drive(1'b1, 2'b01, 5'd3, 1'b0, 1'b0); tick();
      drive(1'b1, 2'b01, 5'd4, 1'b0, 1'b0); tick();
      chk("bp_in_ready_full", DW'(in_ready), 0);
      chk("bp_head_rn", DW'(out_rn), 3);
      drive(1'b0, '0, '0, 1'b0, 1'b0); tick();
      chk("bp_head_stable", DW'(out_rn), 3);
      drive(1'b0, '0, '0, 1'b1, 1'b0); tick();
      chk("bp_second_rn", DW'(out_rn), 4);
      chk("bp_in_ready_after_pop", DW'(in_ready), 1);
      tick();
      chk("bp_drained", DW'(out_valid), 0);

      // Flush while full with a new entry offered in the same cycle.
      drive(1'b1, 2'b11, 5'd1, 1'b0, 1'b0); tick();
      drive(1'b1, 2'b11, 5'd2, 1'b0, 1'b0); tick();
      drive(1'b1, 2'b11, 5'd9, 1'b0, 1'b1); tick();
      chk("flush_valid", DW'(out_valid), 0);
      chk("flush_ctrl", DW'(out_ctrl), 0);
      chk("flush_in_ready", DW'(in_ready), 1);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("flush_no_rn9", DW'(out_valid), 0);
      end

      // Bubble gating of control bits.
      drive(1'b1, 2'b11, 5'd7, 1'b1, 1'b0); tick();
      chk("gate_ctrl_on", DW'(out_ctrl), 2'b11);
      drive(1'b0, 2'b11, 5'd7, 1'b1, 1'b0); tick();
      chk("gate_ctrl_off", DW'(out_ctrl), 0);

      // Randomized traffic with occasional flush.
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom), 5'($urandom),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0));
         tick();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick(); tick(); tick();

`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", DW'(stall_cnt), DW'(stall_m));
      chk("bubble_cnt", DW'(bubble_cnt), DW'(bubble_m));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
